// File: rtl/comb_bcd_converter.sv
// comb_bcd_converter: serial double-dabble binary-to-BCD converter; define COMB_BCD_BLANK_EN to blank leading zero digits.
module comb_bcd_converter #(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] scr_q, scr_d, adj, res, bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
  end
`ifdef COMB_BCD_BLANK_EN
  logic lead;
  always_comb begin
    res = scr_q;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && scr_q[4*i +: 4] == 4'd0) res[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  end
`else
  assign res = scr_q;
`endif
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        bin_d   = bin_in;
        scr_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(BIN_W - 1) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = res;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign valid   = valid_q;
  assign bcd_out = bcd_q;
endmodule

// File: tb/tb_comb_bcd_converter.sv
// tb_comb_bcd_converter: directed self-checking bench for comb_bcd_converter.
module tb_comb_bcd_converter;
  logic        clk = 1'b0;
  logic        rst, start, busy, valid;
  logic [14:0] bin_in;
  logic [19:0] bcd_out;
  int          n_checks = 0, n_fail = 0;
  comb_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .valid(valid), .bcd_out(bcd_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] disp(input logic [19:0] plain);
    logic [19:0] r;
    r = plain;
`ifdef COMB_BCD_BLANK_EN
    for (int i = 4; i > 0; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction
  task automatic conv(input logic [14:0] v, input logic [19:0] plain, input string tag);
    int n, nb;
    start = 1'b1;
    bin_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    nb = busy ? 1 : 0;
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
    check({tag, "_latency"}, n, 16);
    check({tag, "_busy_cycles"}, nb, 16);
    check({tag, "_bcd"}, bcd_out, disp(plain));
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_hold"}, bcd_out, disp(plain));
  endtask
  initial begin
    int pulses, first, m, n;
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_bcd", bcd_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    conv(15'd60, 20'h00060, "c60");
    conv(15'h7FFF, 20'h32767, "cmax");
    conv(15'd0, 20'h00000, "c0");
    conv(15'd10, 20'h00010, "c10");
    start = 1'b1;
    bin_in = 15'd56;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin_in = 15'd999;
    @(posedge clk); #1;
    start = 1'b0;
    bin_in = '0;
    pulses = 0;
    first = 0;
    for (int e = 6; e <= 40; e++) begin
      @(posedge clk); #1;
      if (valid) begin
        pulses++;
        if (first == 0) first = e;
      end
    end
    check("ign_pulses", pulses, 1);
    check("ign_latency", first, 16);
    check("ign_bcd", bcd_out, disp(20'h00056));
    start = 1'b1;
    bin_in = 15'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_bcd", bcd_out, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("mid_rst_no_pulse", pulses, 0);
    conv(15'd1234, 20'h01234, "c1234");
    start = 1'b1;
    bin_in = 15'd6;
    @(posedge clk); #1;
    bin_in = 15'd20;
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", n, 16);
    check("b2b_first_bcd", bcd_out, disp(20'h00006));
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (!valid && m < 40);
    start = 1'b0;
    check("b2b_gap", m, 17);
    check("b2b_second_bcd", bcd_out, disp(20'h00020));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/comb_bcd_converter.md
Name: comb_bcd_converter

Overview:
- Downstream stage of the combination/permutation top level.
- Captures the 15-bit binary `answer` when that block raises `Done`, then converts it serially (shift-and-add-3, "double dabble") into packed BCD digits for the 7-segment display driver.
- One iteration per clock; signals completion with a one-cycle `valid` pulse and holds the result until the next conversion.

Parameters:
- BIN_W, 15, width of the binary input. Matches the `answer` width.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1.
- CNT_W, 4, width of the iteration counter. Must hold BIN_W.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- start  in  1  conversion request; wired to the upstream `Done`; sampled each rising edge.
- bin_in  in  BIN_W  binary value to convert; wired to upstream `answer`.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when `bcd_out` has been updated.
- bcd_out  out  4*DIGITS  packed BCD; bits [3:0] are units, bits [4*DIGITS-1:4*DIGITS-4] are the most significant digit.

Behaviour:
- Reset: rst high at a rising edge forces the following, regardless of state, including mid-conversion:
  - state = IDLE, busy = 0, valid = 0, bcd_out = 0.
  - Shift register and counter = 0.
  - An in-flight conversion is discarded with no valid pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0.
  - On an edge with start = 1: latch bin_in into the binary shift register, clear the BCD scratch register, set count = 0, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT:
  - busy = 1.
  - Each edge performs one iteration:
    - every scratch digit >= 5 gets +3 (all digits corrected in parallel);
    - then {scratch, binreg} shifts left by 1, with the binreg MSB entering scratch bit 0;
    - count increments.
  - After the iteration with count = BIN_W-1 (the BIN_W-th iteration), go to DONE.
- DONE:
  - busy = 1.
  - On the next edge: copy scratch to bcd_out, pulse valid = 1 for exactly that following cycle, go to IDLE.
- Latency:
  - start sampled at edge E0.
  - Iterations occur at edges E1..E15.
  - bcd_out is updated and valid rises at edge E16, and valid is low again after E17.
  - Total latency is BIN_W+1 cycles.
- bcd_out is registered and holds its value between conversions; it changes only at the DONE->IDLE edge or on reset.
- start while busy (SHIFT/DONE) is ignored; no queuing.
- start held high continuously starts a new conversion at the first IDLE edge after valid, i.e. back-to-back every BIN_W+2 cycles.
- bin_in is sampled only at the accepting edge; later changes have no effect.
- Scratch digits never exceed 9 after correction. Width of the scratch register is 4*DIGITS with no overflow for legal parameters.

Optional Feature:
- Macro: COMB_BCD_BLANK_EN.
- Defined: at the DONE->IDLE edge, leading zero digits of the result are replaced with 4'hF (the display decoder shows 4'hF as blank).
  - Scanning starts at the MSB digit and stops at the first nonzero digit.
  - The units digit is never blanked, so 0 shows as FFFF0.
- Not defined: all digits output as plain BCD, including leading zeros.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset, then start=1 for one cycle with bin_in=60 (5P3) -> busy high for 16 cycles; at edge E16 valid=1 for one cycle and bcd_out=20'h00060 (blank build: 20'hFFF60).
- bin_in=15'h7FFF (32767) -> bcd_out=20'h32767, latency 16 cycles from start edge to valid edge.
- bin_in=0 -> bcd_out=20'h00000 (blank build: 20'hFFFF0); bin_in=10 -> 20'h00010 (blank: 20'hFFF10).
- Start bin_in=56, then pulse start with bin_in=999 at edge E5 -> second request ignored; result 20'h00056, exactly one valid pulse.
- Start bin_in=1234, assert rst at edge E8 -> next cycle busy=0, valid=0, bcd_out=0, no valid pulse; then start 1234 -> 20'h01234.
- start held high, bin_in=6 then 20 changed while busy -> results 20'h00006 then 20'h00020, valid pulses 17 cycles apart.
